// File: rtl/apb_interconnect_n.sv
// APB bridge: one upstream APB master port fanned out to NUM_SLAVES downstream slaves,
// decoded from an address field, with a per-transfer access timeout and an error counter.
module apb_interconnect_n #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_LSB     = 28,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_SLAVES-1:0]        psel_s,
  output logic                         penable_s,
  output logic                         pwrite_s,
  output logic [ADDR_W-1:0]            paddr_s,
  output logic [DATA_W-1:0]            pwdata_s,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_s,
  input  logic [NUM_SLAVES-1:0]        pready_s,
  input  logic [NUM_SLAVES-1:0]        pslverr_s,
  output logic [15:0]                  err_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_SLAVES);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_DERR   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic [NUM_SLAVES-1:0]   psel_s_q, psel_s_d;
  logic                    penable_s_q, penable_s_d;
  logic                    pwrite_s_q, pwrite_s_d;
  logic [ADDR_W-1:0]       paddr_s_q, paddr_s_d;
  logic [DATA_W-1:0]       pwdata_s_q, pwdata_s_d;
  logic [DATA_W-1:0]       prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [15:0]             err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]        dec_idx_c;
  logic                    dec_ok_c;
  logic                    setup_c;
  logic                    sel_ready_c;
  logic                    sel_err_c;
  logic [DATA_W-1:0]       sel_rdata_c;
  logic                    timeout_c;

  assign dec_idx_c = paddr[SEL_LSB +: IDX_W];
  assign dec_ok_c  = (32'(dec_idx_c) < NUM_SLAVES);
  assign setup_c   = psel && !penable;

  // Response mux: only the captured slave's handshake and data are looked at
  always_comb begin
    sel_ready_c = 1'b0;
    sel_err_c   = 1'b0;
    sel_rdata_c = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready_c = pready_s[k];
        sel_err_c   = pslverr_s[k];
        sel_rdata_c = prdata_s[k*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout_c = (state_q == S_ACCESS) && !sel_ready_c && (wait_q == WAIT_LAST);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      psel_s_q    <= '0;
      penable_s_q <= 1'b0;
      pwrite_s_q  <= 1'b0;
      paddr_s_q   <= '0;
      pwdata_s_q  <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      psel_s_q    <= psel_s_d;
      penable_s_q <= penable_s_d;
      pwrite_s_q  <= pwrite_s_d;
      paddr_s_q   <= paddr_s_d;
      pwdata_s_q  <= pwdata_s_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (setup_c) state_d = dec_ok_c ? S_SETUP : S_DERR;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (sel_ready_c || timeout_c) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_DERR:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they appear with it
  always_comb begin
    idx_d       = idx_q;
    wait_d      = wait_q;
    psel_s_d    = '0;
    penable_s_d = 1'b0;
    pwrite_s_d  = pwrite_s_q;
    paddr_s_d   = paddr_s_q;
    pwdata_s_d  = pwdata_s_q;
    prdata_d    = '0;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (state_q == S_IDLE && state_d == S_SETUP) begin
      idx_d      = dec_idx_c;
      paddr_s_d  = paddr;
      pwdata_s_d = pwdata;
      pwrite_s_d = pwrite;
    end

    case (state_d)
      S_SETUP: begin
        for (int unsigned k = 0; k < NUM_SLAVES; k++) psel_s_d[k] = (idx_d == IDX_W'(k));
      end
      S_ACCESS: begin
        for (int unsigned k = 0; k < NUM_SLAVES; k++) psel_s_d[k] = (idx_q == IDX_W'(k));
        penable_s_d = 1'b1;
        wait_d      = (state_q == S_SETUP) ? '0 : wait_q + CNT_W'(1);
      end
      S_DONE: begin
        pready_d = 1'b1;
        if (sel_ready_c) begin
          pslverr_d = sel_err_c;
          prdata_d  = pwrite_s_q ? '0 : sel_rdata_c;
        end else begin
          pslverr_d = 1'b1;
        end
      end
      S_DERR: begin
        pready_d  = 1'b1;
        pslverr_d = 1'b1;
      end
      default: ;
    endcase

    if (pready_d && pslverr_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  assign psel_s    = psel_s_q;
  assign penable_s = penable_s_q;
  assign pwrite_s  = pwrite_s_q;
  assign paddr_s   = paddr_s_q;
  assign pwdata_s  = pwdata_s_q;
  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign err_cnt   = err_cnt_q;

endmodule
